vga_clock_digit_renderer: RTL and testbench
===========================================

// Module: vga_clock_digit_renderer
// PURPOSE
//  Pixel stage downstream of the VGA sync counter. Consumes Qh/Qv/H_ON/V_ON/H_Syncreg/V_Syncreg.
//  Renders "HH:MM:SS" (8 glyphs, 8x16 font, scaled) centred on the 640x480 active area.
//  Drives 12-bit RGB plus delayed syncs to the DAC pins.
//  Digits load from the time-keeping logic through a valid/ready handshake; frame-synchronous update, no tearing.
// PARAMETERS
//  H_OFFSET  49       Qh value of active pixel x=0
//  V_OFFSET  34       Qv value of active line y=0
//  SCALE_LG2 2        glyph scale = 2^SCALE_LG2 (default 4 -> 32x64 px per glyph)
//  X0        192      left edge of glyph string, active-area pixels
//  Y0        208      top edge of glyph string, active-area pixels
//  FG        12'hFFF  foreground colour
//  BG        12'h000  background colour inside active area
// PORTS
//  reloj     in   1   system clock (same clock as sync counter)
//  resetM    in   1   synchronous active-high reset
//  Qh        in   10  horizontal count 0..800
//  Qv        in   10  vertical count 0..525
//  H_ON      in   1   horizontal active
//  V_ON      in   1   vertical active
//  H_Sync    in   1   horizontal sync from counter
//  V_Sync    in   1   vertical sync from counter
//  dig_in    in   24  BCD {h1,h0,m1,m0,s1,s0}, h1 = leftmost glyph
//  dig_valid in   1   dig_in valid
//  dig_ready out  1   renderer can accept dig_in
//  rgb       out  12  {R[3:0],G[3:0],B[3:0]}
//  hsync_o   out  1   H_Sync delayed to match rgb
//  vsync_o   out  1   V_Sync delayed to match rgb
// BEHAVIOUR
//  Reset: rgb=0, hsync_o=1, vsync_o=1, dig_ready=1, pending/display digits=0, pend_flag=0, frame cnt=0.
//  Pipeline: fixed 2 reloj cycles, inputs -> rgb/hsync_o/vsync_o. All three are delayed identically.
//   S1: active=H_ON&V_ON; x=Qh-H_OFFSET, y=Qv-V_OFFSET (10-bit, wrap ignored when !active).
//       gx=x-X0, gy=y-Y0; in_box = active & x>=X0 & x<X0+(64<<SCALE_LG2) & y>=Y0 & y<Y0+(16<<SCALE_LG2).
//       glyph=gx>>(SCALE_LG2+3); col=(gx>>SCALE_LG2)&7; row=(gy>>SCALE_LG2)&15. Register all.
//   S2: code = digit nibble for glyph 0,1,3,4,6,7; colon code for glyph 2,5.
//       Font ROM is a case table, row -> 8 bits, MSB = leftmost; bit = rom[code][row][7-col].
//       rgb = !active ? 0 : (in_box & bit) ? FG : BG.
//  Nibble >9: renders blank (all-zero glyph rows), no error flag.
//  Colon glyph: 2x2-font-pixel dots at font rows 4-5 and 10-11, cols 3-4.
//  Frame start: one-cycle pulse fs when registered Qv!=0 and current Qv==0 (incl. 525->0 wrap). No fs on the first cycle after reset.
//  Handshake:
//   - dig_ready = !pend_flag.
//   - dig_valid & dig_ready: capture dig_in into pending, set pend_flag.
//   - fs & pend_flag: display <= pending, clear pend_flag (ready high next cycle).
//   - fs and an accept in the same cycle: accept first, the new value is copied by that fs. Net: pend_flag stays 0, display = dig_in.
//   - Multiple values per frame: only one is accepted; later ones stall.
//  Display digits change only on fs: no mid-frame change.
//  Reset mid-frame: clears all state; output is BG/black until the next active pixels.
//  Latency from dig_valid accept to visible: until the next fs, at most 1 frame.
// CONFIGURATION
//  BLINK_COLON_EN defined:
//   - 6-bit frame counter increments on each fs and wraps at 59 -> 0.
//   - Colon glyphs render blank while count>=30: 0.5 s on / 0.5 s off at 60 Hz.
//   - Counter resets to 0.
//  BLINK_COLON_EN undefined: no counter; colons always drawn.
// TESTING
//  1 Reset held 3 cycles -> rgb=0, hsync_o=1, vsync_o=1, dig_ready=1.
//  2 Sync delay: drive H_Sync 1->0 at cycle N -> hsync_o 1->0 at cycle N+2. Same check for V_Sync.
//  3 Load: dig_in=24'h123456 accepted mid-frame -> dig_ready=0; rows Y0..Y0+63 still show 00:00:00 until fs; next frame shows 12:34:56; dig_ready=1 the cycle after fs.
//  4 Pixel check, display=24'h000000:
//    - Qh=49+192, Qv=34+208 -> rgb at +2 cycles = rom['0'][0][7] ? FG : BG.
//    - Qh=49+191 -> BG.
//    - H_ON=0 -> 0.
//  5 Boundary:
//    - dig_valid with dig_in=24'hA00000 accepted in the same cycle as fs -> display updates that frame; glyph0 blank; dig_ready stays 1.
//  6 BLINK_COLON_EN build, 60 frames -> colon pixels FG in frames 0-29, BG in frames 30-59; digits unaffected.

Source files
------------

// File: rtl/vga_clock_digit_renderer.sv
// Pixel stage after the VGA sync counter: draws "HH:MM:SS" from an 8x16 font and delays the syncs to match.
// Optional build macro BLINK_COLON_EN: colons blink at 0.5 s on / 0.5 s off, timed by a 60-frame counter.
module vga_clock_digit_renderer #(
  parameter int unsigned H_OFFSET  = 49,
  parameter int unsigned V_OFFSET  = 34,
  parameter int unsigned SCALE_LG2 = 2,
  parameter int unsigned X0        = 192,
  parameter int unsigned Y0        = 208,
  parameter logic [11:0] FG        = 12'hFFF,
  parameter logic [11:0] BG        = 12'h000
) (
  input  logic        reloj,
  input  logic        resetM,
  input  logic [9:0]  Qh,
  input  logic [9:0]  Qv,
  input  logic        H_ON,
  input  logic        V_ON,
  input  logic        H_Sync,
  input  logic        V_Sync,
  input  logic [23:0] dig_in,
  input  logic        dig_valid,
  output logic        dig_ready,
  output logic [11:0] rgb,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + (64 << SCALE_LG2));
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + (16 << SCALE_LG2));

  // Glyph codes 0..15 are digit nibbles (10..15 blank); colon and blank-colon sit above them.
  localparam logic [4:0] CODE_COLON = 5'h10;
  localparam logic [4:0] CODE_BLANK = 5'h1F;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_t;

  // Each glyph is 16 rows of 8 bits, row 0 in the top byte, MSB = leftmost pixel.
  function automatic logic [127:0] glyph_rom(input logic [4:0] code);
    logic [127:0] g;
    g = '0;
    case (code)
      5'h00:      g = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      5'h01:      g = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      5'h02:      g = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
      5'h03:      g = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
      5'h04:      g = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
      5'h05:      g = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
      5'h06:      g = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
      5'h07:      g = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
      5'h08:      g = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
      5'h09:      g = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
      CODE_COLON: g = 128'h0000_0000_1818_0000_0000_1818_0000_0000;
      default:    g = '0;
    endcase
    return g;
  endfunction

  // ---------------- Stage 1: coordinates ----------------
  logic [9:0] x_w, y_w, gx_w, gy_w;
  logic       active_d, in_box_d;
  logic [2:0] glyph_d, col_d;
  logic [3:0] row_d;

  assign x_w      = Qh - 10'(H_OFFSET);
  assign y_w      = Qv - 10'(V_OFFSET);
  assign gx_w     = x_w - 10'(X0);
  assign gy_w     = y_w - 10'(Y0);
  assign active_d = H_ON & V_ON;
  assign in_box_d = active_d
                  & ({1'b0, x_w} >= X_LO) & ({1'b0, x_w} < X_HI)
                  & ({1'b0, y_w} >= Y_LO) & ({1'b0, y_w} < Y_HI);
  assign glyph_d  = 3'(gx_w >> (SCALE_LG2 + 3));
  assign col_d    = 3'(gx_w >> SCALE_LG2);
  assign row_d    = 4'(gy_w >> SCALE_LG2);

  logic       active_q, in_box_q, hs1_q, vs1_q;
  logic [2:0] glyph_q, col_q;
  logic [3:0] row_q;

  always_ff @(posedge reloj) begin
    if (resetM) begin
      active_q <= 1'b0;
      in_box_q <= 1'b0;
      glyph_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      in_box_q <= in_box_d;
      glyph_q  <= glyph_d;
      col_q    <= col_d;
      row_q    <= row_d;
      hs1_q    <= H_Sync;
      vs1_q    <= V_Sync;
    end
  end

  // ---------------- Digit handshake and frame-synchronous update ----------------
  pend_state_t pend_state_q, pend_state_d;
  logic [23:0] pend_dig_q, pend_dig_d;
  logic [23:0] disp_dig_q, disp_dig_d;
  logic [9:0]  qv_prev_q;
  logic        fs_w, accept_w;

  assign fs_w      = (qv_prev_q != 10'd0) && (Qv == 10'd0);
  assign accept_w  = dig_valid && (pend_state_q == PEND_EMPTY);
  assign dig_ready = (pend_state_q == PEND_EMPTY);

  // An accept and a frame start in the same cycle resolve as accept-then-copy.
  always_comb begin
    pend_state_d = pend_state_q;
    pend_dig_d   = pend_dig_q;
    disp_dig_d   = disp_dig_q;
    if (accept_w) begin
      pend_dig_d   = dig_in;
      pend_state_d = PEND_FULL;
    end
    if (fs_w && (pend_state_d == PEND_FULL)) begin
      disp_dig_d   = pend_dig_d;
      pend_state_d = PEND_EMPTY;
    end
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      pend_state_q <= PEND_EMPTY;
      pend_dig_q   <= '0;
      disp_dig_q   <= '0;
      qv_prev_q    <= '0;
    end else begin
      pend_state_q <= pend_state_d;
      pend_dig_q   <= pend_dig_d;
      disp_dig_q   <= disp_dig_d;
      qv_prev_q    <= Qv;
    end
  end

  logic colon_on_w;

`ifdef BLINK_COLON_EN
  logic [5:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (fs_w) begin
      frame_cnt_d = (frame_cnt_q == 6'd59) ? 6'd0 : frame_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign colon_on_w = (frame_cnt_q < 6'd30);
`else
  assign colon_on_w = 1'b1;
`endif

  // ---------------- Stage 2: glyph lookup and colour ----------------
  logic [3:0] nib_w [6];

  genvar gi;
  for (gi = 0; gi < 6; gi++) begin : g_nib
    assign nib_w[gi] = disp_dig_q[23 - 4*gi -: 4];
  end

  logic [4:0]   code_w;
  logic [127:0] bitmap_w;
  logic [7:0]   row_bits_w;
  logic         pix_bit_w;
  logic [11:0]  rgb_d;

  always_comb begin
    code_w     = CODE_BLANK;
    bitmap_w   = '0;
    row_bits_w = '0;
    pix_bit_w  = 1'b0;
    rgb_d      = '0;
    case (glyph_q)
      3'd0:    code_w = {1'b0, nib_w[0]};
      3'd1:    code_w = {1'b0, nib_w[1]};
      3'd3:    code_w = {1'b0, nib_w[2]};
      3'd4:    code_w = {1'b0, nib_w[3]};
      3'd6:    code_w = {1'b0, nib_w[4]};
      3'd7:    code_w = {1'b0, nib_w[5]};
      default: code_w = colon_on_w ? CODE_COLON : CODE_BLANK;
    endcase
    bitmap_w   = glyph_rom(code_w);
    row_bits_w = 8'(bitmap_w >> {4'd15 - row_q, 3'b000});
    pix_bit_w  = row_bits_w[3'd7 - col_q];
    if (!active_q) begin
      rgb_d = '0;
    end else if (in_box_q && pix_bit_w) begin
      rgb_d = FG;
    end else begin
      rgb_d = BG;
    end
  end

  logic [11:0] rgb_q;
  logic        hs2_q, vs2_q;

  always_ff @(posedge reloj) begin
    if (resetM) begin
      rgb_q <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign rgb     = rgb_q;
  assign hsync_o = hs2_q;
  assign vsync_o = vs2_q;

endmodule

// File: tb/tb_vga_clock_digit_renderer.sv
// Directed bench for vga_clock_digit_renderer: a reference model queues expected outputs per
// driven cycle and they are compared two clocks later, alongside dig_ready every cycle.
module tb_vga_clock_digit_renderer;

  logic        reloj = 1'b0;
  logic        resetM = 1'b1;
  logic [9:0]  Qh = '0, Qv = '0;
  logic        H_ON = 1'b0, V_ON = 1'b0, H_Sync = 1'b1, V_Sync = 1'b1;
  logic [23:0] dig_in = '0;
  logic        dig_valid = 1'b0;
  logic        dig_ready;
  logic [11:0] rgb;
  logic        hsync_o, vsync_o;

  vga_clock_digit_renderer dut (
    .reloj(reloj), .resetM(resetM), .Qh(Qh), .Qv(Qv), .H_ON(H_ON), .V_ON(V_ON),
    .H_Sync(H_Sync), .V_Sync(V_Sync), .dig_in(dig_in), .dig_valid(dig_valid),
    .dig_ready(dig_ready), .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 reloj = ~reloj;

  localparam logic [11:0] FGC = 12'hFFF;
  localparam logic [11:0] BGC = 12'h000;

  logic [7:0] font [10][16] = '{
    '{8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hCE,8'hDE,8'hF6,8'hE6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h18,8'h38,8'h78,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'h06,8'h0C,8'h18,8'h30,8'h60,8'hC0,8'hC6,8'hFE,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'h06,8'h06,8'h3C,8'h06,8'h06,8'h06,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hFE,8'h0C,8'h0C,8'h0C,8'h1E,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'hFE,8'hC0,8'hC0,8'hC0,8'hFC,8'h06,8'h06,8'h06,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h38,8'h60,8'hC0,8'hC0,8'hFC,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'hFE,8'hC6,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h30,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hC6,8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00,8'h00,8'h00},
    '{8'h00,8'h00,8'h7C,8'hC6,8'hC6,8'hC6,8'h7E,8'h06,8'h06,8'h06,8'h0C,8'h78,8'h00,8'h00,8'h00,8'h00}
  };

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference state of the digit path
  logic [23:0] m_pend_dig = '0;
  logic [23:0] m_disp = '0;
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  int          m_qv_prev = 0;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int qh, input int qv, input bit hon, input bit von);
    int x, y, g, c, r, idx, nib;
    bit lit, colon_lit;
    if (!(hon && von)) return 12'h000;
    x = qh - 49;
    y = qv - 34;
    if (x < 192 || x >= 448 || y < 208 || y >= 272) return BGC;
    g = (x - 192) / 32;
    c = ((x - 192) / 4) % 8;
    r = (y - 208) / 4;
`ifdef BLINK_COLON_EN
    colon_lit = (m_cnt < 30);
`else
    colon_lit = 1'b1;
`endif
    if (g == 2 || g == 5) begin
      lit = colon_lit && (r == 4 || r == 5 || r == 10 || r == 11) && (c == 3 || c == 4);
    end else begin
      idx = (g < 2) ? g : (g < 5) ? g - 1 : g - 2;
      nib = int'((m_disp >> (4 * (5 - idx))) & 24'hF);
      lit = (nib <= 9) ? font[nib][r][7 - c] : 1'b0;
    end
    return lit ? FGC : BGC;
  endfunction

  task automatic step(input int qh, input int qv, input bit hon, input bit von,
                      input bit hs, input bit vs, input bit rst, input bit vld,
                      input logic [23:0] din, input string tag);
    exp_t e;
    bit   fs;
    @(negedge reloj);
    Qh = 10'(qh); Qv = 10'(qv); H_ON = hon; V_ON = von;
    H_Sync = hs; V_Sync = vs; resetM = rst; dig_valid = vld; dig_in = din;
    if (rst) begin
      foreach (sb[i]) begin
        sb[i].rgb = 12'h000; sb[i].hs = 1'b1; sb[i].vs = 1'b1;
      end
      m_pend = 1'b0; m_pend_dig = '0; m_disp = '0; m_cnt = 0; m_qv_prev = 0;
      e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
    end else begin
      fs = (m_qv_prev != 0) && (qv == 0);
      if (vld && !m_pend) begin
        m_pend_dig = din;
        m_pend = 1'b1;
      end
      if (fs && m_pend) begin
        m_disp = m_pend_dig;
        m_pend = 1'b0;
      end
      if (fs) m_cnt = (m_cnt == 59) ? 0 : m_cnt + 1;
      m_qv_prev = qv;
      e.rgb = model_rgb(qh, qv, hon, von);
      e.hs = hs;
      e.vs = vs;
    end
    e.due = cyc + 2;
    e.tag = tag;
    sb.push_back(e);
    @(posedge reloj);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check({"rgb/", e.tag}, rgb, e.rgb);
      check({"hsync/", e.tag}, {11'b0, hsync_o}, {11'b0, e.hs});
      check({"vsync/", e.tag}, {11'b0, vsync_o}, {11'b0, e.vs});
    end
    check({"ready/", tag}, {11'b0, dig_ready}, {11'b0, !m_pend});
  endtask

  task automatic idle(input int qv, input string tag);
    step(0, qv, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, tag);
  endtask

  task automatic pix(input int g, input int c, input int r, input string tag);
    step(49 + 192 + g*32 + c*4 + 1, 34 + 208 + r*4 + 1, 1'b1, 1'b1, 1'b1, 1'b1,
         1'b0, 1'b0, 24'h0, tag);
  endtask

  task automatic load(input logic [23:0] d, input string tag);
    step(49 + 10, 34 + 10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, d, tag);
  endtask

  task automatic frame_start(input bit vld, input logic [23:0] d, input string tag);
    idle(524, {tag, "/pre"});
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, vld, d, {tag, "/fs"});
  endtask

  initial begin
    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0, "reset");
    idle(1, "post_reset0");
    idle(1, "post_reset1");

    // Sync delay
    step(0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, "hs_low");
    step(0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, "hs_low2");
    step(0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, "vs_low");
    step(0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, "vs_high");

    // Pixels with display 00:00:00
    pix(0, 0, 0, "zero_r0c0");
    step(49 + 191, 34 + 208, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, "left_of_box");
    step(49 + 192, 34 + 208, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, "h_off");
    pix(0, 0, 3, "zero_r3c0");
    pix(2, 3, 4, "colon_dot");
    pix(2, 3, 3, "colon_gap");
    pix(7, 7, 11, "last_col");

    // Load mid-frame; second value stalls
    load(24'h123456, "load");
    pix(0, 0, 3, "old_until_fs");
    load(24'h654321, "stall");
    pix(1, 1, 2, "still_old");
    frame_start(1'b0, 24'h0, "fs1");
    idle(1, "after_fs1");
    pix(0, 0, 3, "h1_is_1");
    pix(1, 1, 2, "h0_is_2");
    pix(3, 0, 2, "m1_is_3");
    pix(4, 4, 7, "m0_is_4");
    pix(6, 0, 6, "s1_is_5");
    pix(7, 0, 6, "s0_is_6");
    pix(5, 4, 10, "colon2_dot");

    // Accept coincident with frame start, blank nibble
    frame_start(1'b1, 24'hA00000, "fs_accept");
    idle(1, "after_fs_accept");
    pix(0, 0, 3, "blank_glyph0");
    pix(0, 1, 2, "blank_glyph0b");
    pix(1, 0, 3, "zero_glyph1");

    // Mid-frame reset clears displayed and pending digits
    load(24'h999999, "load9");
    frame_start(1'b0, 24'h0, "fs9");
    idle(1, "after_fs9");
    pix(0, 1, 2, "nine");
    load(24'h888888, "load8");
    pix(0, 0, 3, "pre_reset");
    step(49 + 200, 34 + 220, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0, "reset_mid");
    pix(0, 0, 3, "after_reset");
    pix(0, 0, 3, "after_reset2");
    frame_start(1'b0, 24'h0, "fs_after_reset");
    idle(1, "after_fs_reset");
    pix(0, 0, 3, "pending_cleared");

    // Sixty frames of colon and digit pixels
    for (int f = 0; f < 60; f++) begin
      pix(2, 3, 4, $sformatf("colon_f%0d", f));
      pix(0, 0, 3, $sformatf("digit_f%0d", f));
      frame_start(1'b0, 24'h0, $sformatf("blink_f%0d", f));
    end

    idle(1, "drain0");
    idle(1, "drain1");
    idle(1, "drain2");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
